// File: rtl/pc_full_subsystem.sv
// pc_full_subsystem
//   Program-counter update subsystem of the 16-bit accumulator processor.
//   Holds the PC register and loads it, when enabled, from one of:
//   the ALU branch target, a pseudo-direct jump address built from the
//   instruction immediate, or the sequential PC + PC_INC.
// Ports
//   CLK             in   system clock, rising-edge state updates
//   Reset           in   synchronous active-low reset (loads RESET_PC)
//   IR              in   jump immediate field of the current instruction
//   PCSource        in   next-PC select: 0=ALU, 1=jump, 2=PC+PC_INC, 3=hold
//   ALUbranchOutput in   branch target from the ALU (loaded verbatim)
//   PCwrite         in   PC write enable, active-high
//   NewPC           out  registered PC, no combinational bypass
module pc_full_subsystem #(
  parameter int unsigned PC_WIDTH  = 16,
  parameter int unsigned IMM_WIDTH = 13,
  parameter int unsigned PC_INC    = 2,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic [IMM_WIDTH-1:0] IR,
  input  logic [1:0]           PCSource,
  input  logic [PC_WIDTH-1:0]  ALUbranchOutput,
  input  logic                 PCwrite,
  output logic [PC_WIDTH-1:0]  NewPC
);

  typedef enum logic [1:0] {
    SRC_ALU  = 2'd0,
    SRC_JUMP = 2'd1,
    SRC_INC  = 2'd2,
    SRC_HOLD = 2'd3
  } pc_src_e;

  localparam logic [PC_WIDTH-1:0] INC_VAL   = PC_WIDTH'(PC_INC);
  localparam logic [PC_WIDTH-1:0] RESET_VAL = PC_WIDTH'(RESET_PC);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] next_pc;
  logic [PC_WIDTH-1:0] jump_addr;
  logic [PC_WIDTH-1:0] inc_addr;

  // Jump keeps the PC's upper region bits and places the immediate as a
  // halfword offset, so the target is always even.
  assign jump_addr = {pc_q[PC_WIDTH-1:IMM_WIDTH+1], IR, 1'b0};

  // Carry out is discarded: the PC wraps modulo 2^PC_WIDTH.
  assign inc_addr = pc_q + INC_VAL;

  always_comb begin
    next_pc = pc_q;
    unique case (pc_src_e'(PCSource))
      SRC_ALU:  next_pc = ALUbranchOutput;
      SRC_JUMP: next_pc = jump_addr;
      SRC_INC:  next_pc = inc_addr;
      SRC_HOLD: next_pc = pc_q;
      default:  next_pc = pc_q;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (PCwrite) pc_d = next_pc;
  end

  always_ff @(posedge CLK) begin
    if (!Reset) pc_q <= RESET_VAL;
    else        pc_q <= pc_d;
  end

  assign NewPC = pc_q;

endmodule

// File: tb/tb_pc_full_subsystem.sv
module tb_pc_full_subsystem;

  logic        CLK;
  logic        Reset;
  logic [12:0] IR;
  logic [1:0]  PCSource;
  logic [15:0] ALUbranchOutput;
  logic        PCwrite;
  logic [15:0] NewPC;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } exp_t;

  exp_t sb_q[$];

  pc_full_subsystem #(
    .PC_WIDTH (16),
    .IMM_WIDTH(13),
    .PC_INC   (2),
    .RESET_PC (0)
  ) dut (
    .CLK            (CLK),
    .Reset          (Reset),
    .IR             (IR),
    .PCSource       (PCSource),
    .ALUbranchOutput(ALUbranchOutput),
    .PCwrite        (PCwrite),
    .NewPC          (NewPC)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Drive one vector at the falling edge, queue its hand-computed result,
  // then let the rising edge consume it.
  task automatic step(input string name, input logic rst_n, input logic we,
                      input logic [1:0] src, input logic [15:0] alu,
                      input logic [12:0] ir, input logic [15:0] exp);
    exp_t e;
    @(negedge CLK);
    Reset           = rst_n;
    PCwrite         = we;
    PCSource        = src;
    ALUbranchOutput = alu;
    IR              = ir;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
    @(posedge CLK);
  endtask

  // Monitor: NewPC is valid 1 time unit after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        total++;
        if (NewPC !== e.exp) begin
          bad++;
          $display("FAIL %s: NewPC=%h expected=%h", e.name, NewPC, e.exp);
        end
      end
    end
  end

  initial begin
    Reset = 1'b0; PCwrite = 1'b0; PCSource = 2'd0;
    ALUbranchOutput = '0; IR = '0;

    step("reset",        1'b0, 1'b0, 2'd0, 16'h0000, 13'h0000, 16'h0000);
    step("hold_src0",    1'b1, 1'b0, 2'd0, 16'h7000, 13'h03E0, 16'h0000);
    step("hold_src1",    1'b1, 1'b0, 2'd1, 16'h7000, 13'h03E0, 16'h0000);
    step("hold_src2",    1'b1, 1'b0, 2'd2, 16'h7000, 13'h03E0, 16'h0000);
    step("alu_load",     1'b1, 1'b1, 2'd0, 16'h7000, 13'h03E0, 16'h7000);
    step("jump_01",      1'b1, 1'b1, 2'd1, 16'h0000, 13'h03E0, 16'h47C0);
    step("inc",          1'b1, 1'b1, 2'd2, 16'h0000, 13'h0000, 16'h47C2);
    step("src3_hold",    1'b1, 1'b1, 2'd3, 16'hAAAA, 13'h1555, 16'h47C2);
    step("alu_fffe",     1'b1, 1'b1, 2'd0, 16'hFFFE, 13'h0000, 16'hFFFE);
    step("inc_wrap",     1'b1, 1'b1, 2'd2, 16'h0000, 13'h0000, 16'h0000);
    step("alu_odd",      1'b1, 1'b1, 2'd0, 16'h1235, 13'h0000, 16'h1235);
    step("inc_odd",      1'b1, 1'b1, 2'd2, 16'h0000, 13'h0000, 16'h1237);
    step("alu_c001",     1'b1, 1'b1, 2'd0, 16'hC001, 13'h0000, 16'hC001);
    step("jump_11_max",  1'b1, 1'b1, 2'd1, 16'h0000, 13'h1FFF, 16'hFFFE);
    step("inc_wrap2",    1'b1, 1'b1, 2'd2, 16'h0000, 13'h0000, 16'h0000);
    step("we0_ignore",   1'b1, 1'b0, 2'd0, 16'hABCD, 13'h0000, 16'h0000);
    step("alu_47c2",     1'b1, 1'b1, 2'd0, 16'h47C2, 13'h0000, 16'h47C2);
    step("reset_wins",   1'b0, 1'b1, 2'd0, 16'h7000, 13'h03E0, 16'h0000);
    step("alu_2000",     1'b1, 1'b1, 2'd0, 16'h2000, 13'h0000, 16'h2000);

    // A write request that is withdrawn while CLK is still low must not
    // leave any trace on the PC.
    @(negedge CLK);
    PCwrite = 1'b1; PCSource = 2'd0; ALUbranchOutput = 16'h5555;
    #2;
    PCwrite = 1'b0;
    sb_q.push_back('{name: "low_glitch", exp: 16'h2000});
    @(posedge CLK);

    step("hold_after",   1'b1, 1'b0, 2'd2, 16'h0000, 13'h0000, 16'h2000);

    // Drain: every queued expectation must have been consumed.
    repeat (3) @(posedge CLK);
    #2;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d expected=0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
